// File: rtl/gpu_data_memory_if.sv
// gpu_data_memory_if: controller-to-memory request/response bundle.
//   master (controller): drives req, rw, addr, wdata, core_id; sees busy, mready, rdata, rcore_id
//   slave  (memory)    : the reverse
interface gpu_data_memory_if #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 16,
  parameter int CORE_ID_WIDTH = 2
);
  logic                     req;
  logic                     rw;
  logic [ADDR_WIDTH-1:0]    addr;
  logic [DATA_WIDTH-1:0]    wdata;
  logic [CORE_ID_WIDTH-1:0] core_id;
  logic                     busy;
  logic                     mready;
  logic [DATA_WIDTH-1:0]    rdata;
  logic [CORE_ID_WIDTH-1:0] rcore_id;
  modport master (output req, rw, addr, wdata, core_id, input busy, mready, rdata, rcore_id);
  modport slave  (input req, rw, addr, wdata, core_id, output busy, mready, rdata, rcore_id);
endinterface

// File: rtl/gpu_data_memory.sv
// gpu_data_memory: shared data memory serving one granted request at a time with fixed latency.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of gpu_data_memory_if (req/rw/addr/wdata/core_id in;
//           busy/mready/rdata/rcore_id out)
module gpu_data_memory #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 16,
  parameter int CORE_ID_WIDTH = 2,
  parameter int LATENCY       = 2
) (
  input  logic             clock,
  input  logic             reset,
  gpu_data_memory_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic [3:0] LOAD = 4'(LATENCY - 1);
  state_t                   state, state_next;
  logic [3:0]               count;
  logic                     rw_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [CORE_ID_WIDTH-1:0] core_id_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic [CORE_ID_WIDTH-1:0] rcore_id_q;
  logic [DATA_WIDTH-1:0]    mem [2**ADDR_WIDTH];
  logic                     accept, commit;
  assign accept       = state == IDLE && bus.req;
  assign commit       = state == ACCESS && count == 4'd0;
  assign bus.busy     = state != IDLE;
  assign bus.mready   = state == DONE;
  assign bus.rdata    = rdata_q;
  assign bus.rcore_id = rcore_id_q;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.req) state_next = ACCESS;
      ACCESS:  if (count == 4'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_id_q  <= '0;
      rdata_q    <= '0;
      rcore_id_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        rw_q      <= bus.rw;
        addr_q    <= bus.addr;
        wdata_q   <= bus.wdata;
        core_id_q <= bus.core_id;
        count     <= LOAD;
      end else if (state == ACCESS && count != 4'd0) begin
        count <= count - 4'd1;
      end
      if (commit) begin
        rdata_q    <= rw_q ? wdata_q : mem[addr_q];
        rcore_id_q <= core_id_q;
      end
    end
  end
  // Array kept free of reset so it maps onto RAM; an in-flight write is dropped
  // because reset forces state to IDLE, which suppresses commit.
  always_ff @(posedge clock) begin
    if (commit && rw_q) mem[addr_q] <= wdata_q;
  end
endmodule

// File: tb/tb_gpu_data_memory.sv
// tb_gpu_data_memory: scoreboard bench over three builds (LATENCY 2, 1, 15).
module tb_gpu_data_memory;
  localparam int LATS [3] = '{2, 1, 15};
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [2:0]       req = '0, rw = '0;
  logic [2:0][7:0]  addr = '0;
  logic [2:0][15:0] wdata = '0;
  logic [2:0][1:0]  core_id = '0;
  logic [2:0]       busy, mready;
  logic [2:0][15:0] rdata;
  logic [2:0][1:0]  rcore_id;
  int cyc = 0, errors = 0, checks = 0;
  typedef struct {
    int          lane;
    int          due;
    logic [15:0] data;
    logic [1:0]  cid;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : lane
    gpu_data_memory_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .CORE_ID_WIDTH(2)) bus ();
    assign bus.req     = req[g];
    assign bus.rw      = rw[g];
    assign bus.addr    = addr[g];
    assign bus.wdata   = wdata[g];
    assign bus.core_id = core_id[g];
    assign busy[g]     = bus.busy;
    assign mready[g]   = bus.mready;
    assign rdata[g]    = bus.rdata;
    assign rcore_id[g] = bus.rcore_id;
    gpu_data_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .CORE_ID_WIDTH(2), .LATENCY(LATS[g])) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
    );
  end

  // Any mready must match the oldest pending expectation for its lane, at its due cycle.
  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (mready[i] === 1'b1) begin
        int k;
        k = -1;
        for (int j = 0; j < sb.size(); j++) if (k < 0 && sb[j].lane == i) k = j;
        checks++;
        if (k < 0) begin
          errors++;
          $display("FAIL unexpected_mready lane%0d cycle=%0d rdata=%h rcore_id=%0d", i, cyc, rdata[i], rcore_id[i]);
        end else begin
          if (cyc != sb[k].due || rdata[i] !== sb[k].data || rcore_id[i] !== sb[k].cid) begin
            errors++;
            $display("FAIL resp lane%0d got cyc=%0d rdata=%h rcore_id=%0d want cyc=%0d rdata=%h rcore_id=%0d",
                     i, cyc, rdata[i], rcore_id[i], sb[k].due, sb[k].data, sb[k].cid);
          end
          sb.delete(k);
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic check_reset_vals(string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_busy"}, 32'(busy[i]), 0);
      chk({tag, "_mready"}, 32'(mready[i]), 0);
      chk({tag, "_rdata"}, 32'(rdata[i]), 0);
      chk({tag, "_rcore_id"}, 32'(rcore_id[i]), 0);
    end
  endtask

  task automatic expect_resp(int l, int due, logic [15:0] d, logic [1:0] c);
    exp_t e;
    e.lane = l;
    e.due  = due;
    e.data = d;
    e.cid  = c;
    sb.push_back(e);
  endtask

  // One request; every field is scrambled right after acceptance to prove latching.
  task automatic issue(int l, logic w, logic [7:0] a, logic [15:0] d, logic [1:0] c, logic [15:0] exp_d);
    @(negedge clock);
    req[l] = 1'b1; rw[l] = w; addr[l] = a; wdata[l] = d; core_id[l] = c;
    expect_resp(l, cyc + 1 + LATS[l], exp_d, c);
    @(negedge clock);
    req[l] = 1'b0; rw[l] = ~w; addr[l] = ~a; wdata[l] = ~d; core_id[l] = ~c;
    chk("busy_after_accept", 32'(busy[l]), 1);
  endtask

  task automatic wait_idle(int l);
    int n;
    n = 0;
    while (busy[l] && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) chk("wait_idle_timeout", 32'(busy[l]), 0);
  endtask

  // Hold a read request for n edges: accepted at E0 and again at E0+LATENCY+2 only.
  task automatic hold(int l, logic [7:0] a, logic [1:0] c, logic [15:0] exp_d, int n);
    int e0;
    @(negedge clock);
    req[l] = 1'b1; rw[l] = 1'b0; addr[l] = a; core_id[l] = c;
    e0 = cyc + 1;
    expect_resp(l, e0 + LATS[l], exp_d, c);
    expect_resp(l, e0 + 2 * LATS[l] + 2, exp_d, c);
    repeat (n) @(negedge clock);
    req[l] = 1'b0;
    wait_idle(l);
  endtask

  initial begin
    #1 reset = 1'b0;
    #1 check_reset_vals("por");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    issue(0, 1'b1, 8'h12, 16'hBEEF, 2'd3, 16'hBEEF); wait_idle(0);
    issue(0, 1'b0, 8'h12, 16'h0000, 2'd1, 16'hBEEF); wait_idle(0);
    issue(0, 1'b1, 8'h05, 16'h0000, 2'd2, 16'h0000); wait_idle(0);
    issue(0, 1'b0, 8'h12, 16'h0000, 2'd3, 16'hBEEF); wait_idle(0);
    @(negedge clock);
    req[0] = 1'b1; rw[0] = 1'b1; addr[0] = 8'h05; wdata[0] = 16'h1234; core_id[0] = 2'd1;
    @(negedge clock);
    req[0] = 1'b0;
    #3 reset = 1'b0;
    #1 check_reset_vals("mid_reset");
    repeat (3) @(negedge clock);
    reset = 1'b1;
    issue(0, 1'b0, 8'h05, 16'hFFFF, 2'd2, 16'h0000); wait_idle(0);
    hold(0, 8'h12, 2'd0, 16'hBEEF, 6);
    issue(0, 1'b1, 8'hFF, 16'hA5A5, 2'd0, 16'hA5A5); wait_idle(0);
    issue(0, 1'b1, 8'h00, 16'h5A5A, 2'd1, 16'h5A5A); wait_idle(0);
    issue(0, 1'b0, 8'hFF, 16'h0000, 2'd2, 16'hA5A5); wait_idle(0);
    issue(0, 1'b0, 8'h00, 16'h0000, 2'd3, 16'h5A5A); wait_idle(0);
    issue(1, 1'b1, 8'h40, 16'h1111, 2'd1, 16'h1111); wait_idle(1);
    issue(1, 1'b0, 8'h40, 16'h0000, 2'd2, 16'h1111); wait_idle(1);
    hold(1, 8'h40, 2'd3, 16'h1111, 4);
    issue(2, 1'b1, 8'h80, 16'hF00D, 2'd2, 16'hF00D); wait_idle(2);
    issue(2, 1'b0, 8'h80, 16'h0000, 2'd0, 16'hF00D); wait_idle(2);
    hold(2, 8'h80, 2'd1, 16'hF00D, 18);
    repeat (40) @(negedge clock);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
